// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice.
//   - ALU function codes (ALU_NOT, ALU_NAND, ALU_ADD, ALU_MUL)
//   - Sequencer FSM state encoding (ST_IDLE, ST_EXEC, ST_RESP)
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam logic [1:0] ALU_NOT  = 2'd0;
    localparam logic [1:0] ALU_NAND = 2'd1;
    localparam logic [1:0] ALU_ADD  = 2'd2;
    localparam logic [1:0] ALU_MUL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arbState_t;

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Small combinational ALU shared by the arbiter.
// Ports:
//   a, b  : 2-bit operands
//   sel   : function code (NOT A, NAND, A+B, A*B)
//   y     : 4-bit result; logic results zero-extended, arithmetic exact
// -----------------------------------------------------------------------------
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            ALU_NOT:  y = {2'b00, ~a};
            ALU_NAND: y = {2'b00, ~(a & b)};
            ALU_ADD:  y = {2'b00, a} + {2'b00, b};
            default:  y = {2'b00, a} * {2'b00, b};
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin selector: picks the first set bit of req_valid
// searching upward from ptr, wrapping modulo N_REQ.
// Ports:
//   req_valid : per-requester valid bits
//   ptr       : highest-priority requester index for this cycle
//   grant     : one-hot grant (all zero when no request is valid)
//   grantIdx  : index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grantIdx
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk the candidates from lowest priority to highest so the last match
    // written is the closest one to ptr.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        sum      = '0;
        idx      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req_valid[idx]) begin
                grantIdx = idx;
            end
        end
        if (|req_valid) begin
            grant[grantIdx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter/sequencer sharing one ALU between N_REQ requesters.
// One operation is in flight at a time: IDLE (grant) -> EXEC (ALU) -> RESP.
// Ports:
//   clk, nrst             : clock, asynchronous active-low reset
//   req_valid / req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b, req_sel : packed 2-bit fields, requester i at [2i+1:2i]
//   rsp_valid / rsp_ready : response handshake
//   rsp_y, rsp_id         : ALU result and owning requester index
//   busy                  : high whenever the sequencer is not idle
//   op_cnt                : completed response handshakes, wraps at 256
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2*N_REQ-1:0]   req_a,
    input  logic [2*N_REQ-1:0]   req_b,
    input  logic [2*N_REQ-1:0]   req_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [3:0]           rsp_y,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy,
    output logic [7:0]           op_cnt
);

    if (N_REQ < 2 || N_REQ > 4 || (1 << ID_W) < N_REQ) begin : gBadParams
        $error("alu_arbiter: N_REQ must be 2..4 and fit in ID_W bits");
    end

    arbState_t       state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] opId;
    logic [1:0]      opA;
    logic [1:0]      opB;
    logic [1:0]      opSel;
    logic [3:0]      aluY;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0] grantIdx;
    logic [ID_W:0]   fieldBase;
    logic            reqFire;

    rr_select #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) uSelect (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grantIdx  (grantIdx)
    );

    // Grant is only offered in IDLE; gating with nrst keeps it quiet while
    // reset is asserted regardless of register state.
    assign req_ready = (nrst && state == ST_IDLE) ? grant : '0;
    assign reqFire   = |req_ready;
    assign fieldBase = {grantIdx, 1'b0};

    // The ALU only ever sees the captured operands, never live request inputs.
    alu uAlu (
        .a   (opA),
        .b   (opB),
        .sel (opSel),
        .y   (aluY)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            opId      <= '0;
            opA       <= '0;
            opB       <= '0;
            opSel     <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
            op_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reqFire) begin
                        opA   <= req_a[fieldBase +: 2];
                        opB   <= req_b[fieldBase +: 2];
                        opSel <= req_sel[fieldBase +: 2];
                        opId  <= grantIdx;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_y     <= aluY;
                    rsp_id    <= opId;
                    rsp_valid <= 1'b1;
                    ptr       <= (opId == ID_W'(N_REQ - 1)) ? '0 : opId + 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_cnt    <= op_cnt + 8'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
